// File: rtl/register_file.sv
// 16 x 32-bit register bank with a one-hot decoded write port, two combinational read ports
// and R15 doubling as the program counter. Define REGFILE_BYPASS_EN for same-cycle read forwarding.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PC_INDEX   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  pc_load_enable,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic [DATA_WIDTH-1:0] pc_out
);

    localparam int unsigned            PC_IDX  = PC_INDEX;
    localparam logic [ADDR_WIDTH-1:0]  PC_ADDR = ADDR_WIDTH'(PC_INDEX);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_load_en;

    always_comb begin
        w_load_en = '0;
        if (write_enable) begin
            w_load_en[write_addr] = 1'b1;
        end
    end

    // The general port has priority on R15 so a branch overrides sequential fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_load_en[i]) begin
                    r_regs[i] <= write_data;
                end else if ((i == PC_IDX) && pc_load_enable) begin
                    r_regs[i] <= pc_in;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_pc_fwd;

    assign w_pc_fwd = pc_load_enable && !w_load_en[PC_IDX];

    // Forwarding is suppressed during reset so every output reads 0 while it is held.
    always_comb begin
        read_data_a = r_regs[read_addr_a];
        read_data_b = r_regs[read_addr_b];
        pc_out      = r_regs[PC_IDX];
        if (!reset) begin
            if (write_enable && (read_addr_a == write_addr)) begin
                read_data_a = write_data;
            end else if ((read_addr_a == PC_ADDR) && w_pc_fwd) begin
                read_data_a = pc_in;
            end
            if (write_enable && (read_addr_b == write_addr)) begin
                read_data_b = write_data;
            end else if ((read_addr_b == PC_ADDR) && w_pc_fwd) begin
                read_data_b = pc_in;
            end
            if (w_load_en[PC_IDX]) begin
                pc_out = write_data;
            end else if (w_pc_fwd) begin
                pc_out = pc_in;
            end
        end
    end
`else
    always_comb begin
        read_data_a = r_regs[read_addr_a];
        read_data_b = r_regs[read_addr_b];
        pc_out      = r_regs[PC_IDX];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write sweep, enable gating,
// PC update/collision, dual read, read-during-write and reset release.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        pc_load_enable;
    logic [31:0] pc_in;
    logic [3:0]  read_addr_a;
    logic [3:0]  read_addr_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic [31:0] pc_out;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] exp_regs [16];
    logic [31:0] rdw_exp;

    register_file #(
        .DATA_WIDTH(32),
        .NUM_REGS  (16),
        .ADDR_WIDTH(4),
        .PC_INDEX  (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .pc_load_enable(pc_load_enable),
        .pc_in         (pc_in),
        .read_addr_a   (read_addr_a),
        .read_addr_b   (read_addr_b),
        .read_data_a   (read_data_a),
        .read_data_b   (read_data_b),
        .pc_out        (pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        write_enable   = 1'b0;
        write_addr     = 4'd0;
        write_data     = 32'h0;
        pc_load_enable = 1'b0;
        pc_in          = 32'h0;
        read_addr_a    = 4'd0;
        read_addr_b    = 4'd15;
        #1;
        check("reset_rda", read_data_a, 32'h0);
        check("reset_pc", pc_out, 32'h0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;

        // Reset clears a written register without any clock edge
        write_enable = 1'b1;
        write_addr   = 4'd3;
        write_data   = 32'hDEADBEEF;
        read_addr_a  = 4'd3;
        tick();
        check("r3_written", read_data_a, 32'hDEADBEEF);
        write_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_clear", read_data_a, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("clear_held", read_data_a, 32'h0);

        // Sweep every register
        for (int i = 0; i < 16; i++) begin
            write_enable = 1'b1;
            write_addr   = 4'(i);
            write_data   = 32'h100 + 32'(i);
            exp_regs[i]  = 32'h100 + 32'(i);
            tick();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_addr_a = 4'(i);
            read_addr_b = 4'(i);
            #1;
            check($sformatf("sweep_a_%0d", i), read_data_a, exp_regs[i]);
            check($sformatf("sweep_b_%0d", i), read_data_b, exp_regs[i]);
        end
        check("sweep_pc", pc_out, 32'h10F);

        // Disabled writes change nothing
        write_addr = 4'd5;
        write_data = 32'hFFFFFFFF;
        repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            read_addr_a = 4'(i);
            #1;
            check($sformatf("gate_%0d", i), read_data_a, exp_regs[i]);
        end

        // PC update, collision, and concurrent independent writes
        pc_load_enable = 1'b1;
        pc_in          = 32'h40;
        tick();
        check("pc_load", pc_out, 32'h40);
        read_addr_a = 4'd15;
        #1;
        check("pc_via_a", read_data_a, 32'h40);
        pc_in        = 32'h44;
        write_enable = 1'b1;
        write_addr   = 4'd15;
        write_data   = 32'h200;
        tick();
        check("pc_collision", pc_out, 32'h200);
        write_addr = 4'd1;
        write_data = 32'h11;
        pc_in      = 32'h48;
        tick();
        write_enable   = 1'b0;
        pc_load_enable = 1'b0;
        read_addr_a    = 4'd1;
        #1;
        check("r1_with_pc", read_data_a, 32'h11);
        check("pc_with_r1", pc_out, 32'h48);

        // Dual read of the same register, then a pure address change
        write_enable = 1'b1;
        write_addr   = 4'd7;
        write_data   = 32'h0000_0077;
        tick();
        write_enable = 1'b0;
        read_addr_a  = 4'd7;
        read_addr_b  = 4'd7;
        #1;
        check("dual_a", read_data_a, 32'h77);
        check("dual_b", read_data_b, 32'h77);
        read_addr_b = 4'd8;
        #1;
        check("addr_change_b", read_data_b, 32'h108);

        // Read-during-write
        @(negedge clk);
        read_addr_a  = 4'd2;
        write_enable = 1'b1;
        write_addr   = 4'd2;
        write_data   = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        rdw_exp = 32'hA5A5A5A5;
`else
        rdw_exp = 32'h102;
`endif
        check("rdw_before", read_data_a, rdw_exp);
        tick();
        write_enable = 1'b0;
        #1;
        check("rdw_after", read_data_a, 32'hA5A5A5A5);

        // Edges during reset are ignored; the first edge after release writes
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 4'd4;
        write_data   = 32'h1234;
        read_addr_a  = 4'd4;
        reset        = 1'b1;
        #1;
        check("reset_we_rd", read_data_a, 32'h0);
        check("reset_we_pc", pc_out, 32'h0);
        tick();
        check("reset_edge_ignored", read_data_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        rdw_exp = 32'h1234;
`else
        rdw_exp = 32'h0;
`endif
        check("post_release", read_data_a, rdw_exp);
        read_addr_b = 4'd9;
        #1;
        check("post_release_r9", read_data_b, 32'h0);
        tick();
        write_enable = 1'b0;
        #1;
        check("first_edge_write", read_data_a, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
